// File: rtl/us_timebase.sv
// us_timebase: microsecond timestamp, periodic alarm and event capture,
// all driven by the 1 MHz stime strobe from the RTC divider (same clock domain).
module us_timebase #(
   parameter int unsigned TS_W  = 32,
   parameter int unsigned PER_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stime,
   input  logic             ts_clr,
   output logic [TS_W-1:0]  ts,
   input  logic             per_wr,
   input  logic [PER_W-1:0] per_val,
   input  logic             alarm_en,
   output logic             alarm_pulse,
   output logic             alarm_pend,
   input  logic             alarm_ack,
   input  logic             evt_in,
   output logic [TS_W-1:0]  cap_ts,
   output logic             cap_valid,
   output logic             cap_ovf,
   input  logic             cap_rd
);

   logic             stime_d;
   logic             tick;
   logic [PER_W-1:0] period;
   logic [PER_W-1:0] cnt;
   logic             alarm_step;
   logic             alarm_fire;
   logic             evt_s1;
   logic             evt_s2;
   logic             evt_s3;
   logic             evt_rise;

   // Tick, alarm-step and event-edge qualification
   always_comb begin
      tick       = stime & ~stime_d;
      alarm_step = tick & alarm_en & (period != '0) & ~per_wr;
      alarm_fire = alarm_step & (cnt == PER_W'(1));
      evt_rise   = evt_s2 & ~evt_s3;
   end

   // Strobe edge history; resets high so a strobe already high at release is ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         stime_d <= 1'b1;
      end else begin
         stime_d <= stime;
      end
   end

   // Free-running microsecond timestamp; clear beats the tick
   always_ff @(posedge clk) begin
      if (rst) begin
         ts <= '0;
      end else if (ts_clr) begin
         ts <= '0;
      end else if (tick) begin
         ts <= ts + TS_W'(1);
      end
   end

   // Alarm period register and auto-reloading countdown
   always_ff @(posedge clk) begin
      if (rst) begin
         period <= '0;
         cnt    <= '0;
      end else if (per_wr) begin
         period <= per_val;
         cnt    <= per_val;
      end else if (alarm_step) begin
         if (cnt == PER_W'(1)) begin
            cnt <= period;
         end else begin
            cnt <= cnt - PER_W'(1);
         end
      end
   end

   // Alarm pulse and sticky pending flag; a new expiry wins over ack
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_pulse <= 1'b0;
         alarm_pend  <= 1'b0;
      end else begin
         alarm_pulse <= alarm_fire;
         if (alarm_fire) begin
            alarm_pend <= 1'b1;
         end else if (alarm_ack) begin
            alarm_pend <= 1'b0;
         end
      end
   end

   // Two-flop synchronizer for the asynchronous event plus edge history flop
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_s1 <= 1'b0;
         evt_s2 <= 1'b0;
         evt_s3 <= 1'b0;
      end else begin
         evt_s1 <= evt_in;
         evt_s2 <= evt_s1;
         evt_s3 <= evt_s2;
      end
   end

   // Timestamp capture with overflow tracking; a same-cycle read frees the slot
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_ts    <= '0;
         cap_valid <= 1'b0;
         cap_ovf   <= 1'b0;
      end else if (evt_rise) begin
         if (!cap_valid || cap_rd) begin
            cap_ts    <= ts;
            cap_valid <= 1'b1;
            cap_ovf   <= 1'b0;
         end else begin
            cap_ovf   <= 1'b1;
         end
      end else if (cap_rd) begin
         cap_valid <= 1'b0;
         cap_ovf   <= 1'b0;
      end
   end

endmodule

// File: doc/us_timebase.md
Name: us_timebase

Overview:
- Consumes the 1 MHz `stime` strobe produced by the RTC divider in the same clock domain.
- Maintains a free-running microsecond timestamp.
- Generates a programmable periodic alarm with a sticky pending flag.
- Captures the timestamp on an asynchronous external event, for the control FSMs and the host register interface.

Parameters:
- TS_W, 32, timestamp width in bits.
- PER_W, 16, alarm period register width in bits (unit: microseconds).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- stime  input  1  RTC strobe, synchronous to clk; one tick per rising edge
- ts_clr  input  1  clear timestamp to 0
- ts  output  TS_W  current microsecond timestamp
- per_wr  input  1  load alarm period
- per_val  input  PER_W  alarm period in ticks; 0 = alarm never fires
- alarm_en  input  1  alarm countdown enable
- alarm_pulse  output  1  one-clk pulse on alarm expiry
- alarm_pend  output  1  sticky alarm flag
- alarm_ack  input  1  clears alarm_pend
- evt_in  input  1  asynchronous external event, rising-edge sensitive
- cap_ts  output  TS_W  captured timestamp
- cap_valid  output  1  cap_ts holds unread data
- cap_ovf  output  1  event lost while cap_valid = 1
- cap_rd  input  1  consume capture

Behaviour:
- Reset:
  - rst is synchronous, active-high.
  - All outputs reset to 0: ts, alarm_pulse, alarm_pend, cap_ts, cap_valid, cap_ovf.
  - Period register and countdown register reset to 0.
  - Event synchronizer flops reset to 0.
  - stime_d resets to 1, so a stime level that is already high at reset release is not counted.
  - Reset mid-operation aborts everything; there is no pending state.
- Tick detection:
  - tick = stime & ~stime_d.
  - Exactly one tick per stime rising edge, regardless of high-time (RTC high-time is 5 clk).
- Timestamp:
  - On a tick, ts <= ts + 1; visible the cycle after the tick.
  - Wraps from 2^TS_W-1 to 0 with no flag.
  - ts_clr has priority over the tick: ts <= 0 and that tick is lost.
- Alarm countdown (cnt, PER_W bits):
  - per_wr: period <= per_val and cnt <= per_val.
  - per_wr has priority over the countdown; a tick in the same cycle is not counted by the alarm (ts still increments).
  - On a tick with alarm_en = 1 and period != 0:
    - if cnt == 1: alarm_pulse = 1 for the next clk and cnt <= period (auto-reload);
    - otherwise cnt <= cnt - 1.
  - alarm_en = 0: cnt holds and no pulse is generated. Re-enabling resumes from the held count.
  - period == 0: alarm never fires and cnt is ignored.
  - alarm_pend is set in the same cycle alarm_pulse is asserted and cleared by alarm_ack.
  - Set and ack in the same cycle: set wins, alarm_pend stays 1.
- Event capture:
  - evt_in passes through a 2-FF synchronizer, then a rising-edge detect (evt_rise).
  - evt_in to cap_valid latency is 3 clk.
  - On evt_rise:
    - if cap_valid = 0, or cap_rd = 1 in the same cycle: cap_ts <= ts (registered value in that cycle, before any increment or clear that same cycle) and cap_valid <= 1;
    - otherwise cap_ts holds and cap_ovf <= 1.
  - cap_rd without evt_rise clears cap_valid and cap_ovf.
  - cap_rd together with evt_rise: new capture loads, cap_valid stays 1, cap_ovf <= 0.
- Arithmetic:
  - All counters are unsigned modulo their width.
  - per_val wider than the needed range is the caller's concern; no saturation.

Test Plan:
1. Reset release, then the RTC pattern (stime high 5 clk, low 46 clk, period 51) for 10 periods -> ts = 10; each increment appears 1 clk after the stime rising edge; no increment on the other 4 high cycles.
2. per_wr with per_val = 3, alarm_en = 1, 7 ticks -> alarm_pulse one clk wide after ticks 3 and 6, and alarm_pend = 1. alarm_ack -> alarm_pend = 0. Ack coincident with the next expiry -> alarm_pend stays 1. alarm_en = 0 for 2 ticks -> no pulse and cnt unchanged.
3. TS_W = 4, 17 ticks from reset -> ts sequence 0..15, 0, 1. ts_clr asserted on the same cycle as a tick -> ts = 0 next cycle (not 1).
4. With ts = 5, evt_in pulse -> 3 clk later cap_ts = 5 and cap_valid = 1. Second event before cap_rd -> cap_ts still 5 and cap_ovf = 1. cap_rd -> cap_valid = 0 and cap_ovf = 0.
5. cap_rd coincident with evt_rise while cap_valid = 1 and ts = 9 -> cap_ts = 9, cap_valid = 1, cap_ovf = 0.
6. rst asserted mid-countdown with alarm_pend = 1 and cap_valid = 1 -> all outputs 0 after the next edge. stime held high across reset release -> ts stays 0 until the next stime rising edge.
